psum_ofifo: RTL and testbench
=============================

Name: psum_ofifo

Overview:
- Column-lane output FIFO between the MAC array's bottom row and the per-column sfp accumulator/ReLU stage.
- Each of `col` lanes buffers psums that the array emits independently per column.
- A read pops one aligned word from every lane at once.
- The registered read data and the one-cycle strobe drive each sfp instance's `in` and `i_valid` directly.

Parameters:
- col, 8, number of array columns / lanes
- psum_bw, 16, bits per psum (matches sfp psum_bw)
- depth, 64, entries per lane; power of two, ≥ 2
- Derived: ptr_bw = log2(depth); cnt_bw = ptr_bw + 1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset; 0 = in reset
- wr  input  col  per-lane write enable from array column valid
- in  input  col*psum_bw  lane c data at bits [c*psum_bw +: psum_bw]
- rd  input  1  pop request from the controller
- o_full  output  1  OR of all lane-full flags
- o_ready  output  1  ~o_full; array may issue writes
- o_valid  output  1  AND of all lane-non-empty flags; a row is available
- out  output  col*psum_bw  registered popped row, same lane packing as `in`
- out_strobe  output  1  high for exactly one cycle when `out` carries a newly popped row; wire to every sfp i_valid
- o_overflow  output  col  sticky per-lane flag: a write was dropped on a full lane

Behaviour:
- Reset (reset == 0, async):
  - all wptr, rptr, cnt ← 0
  - out ← 0, out_strobe ← 0, o_overflow ← 0
  - storage array is not reset
  - after release: o_full = 0, o_ready = 1, o_valid = 0
- Per lane c: circular buffer with independent wptr_c, rptr_c, cnt_c.
  - full_c = (cnt_c == depth); empty_c = (cnt_c == 0)
  - Pointers wrap modulo depth (depth−1 → 0).
- Write:
  - If wr[c] and !full_c: mem_c[wptr_c] ← in lane c; wptr_c increments.
  - If wr[c] and full_c: data dropped, pointer unchanged, o_overflow[c] ← 1.
  - o_overflow[c] is cleared only by reset.
- Read acceptance:
  - rd_ok = rd & o_valid, evaluated on pre-edge state.
  - On rd_ok, every lane pops: rptr_c increments.
  - rd while !o_valid is ignored: no pointer change, out holds, no strobe.
- Read data latency = 1 cycle.
  - On rd_ok at edge N, out gets the head entries of all lanes and out_strobe = 1 during cycle N+1.
  - Otherwise out_strobe = 0 and out holds its last value.
- Back-to-back reads: rd held with o_valid high pops one row per cycle; out_strobe stays high continuously.
- Count update: cnt_c' = cnt_c + (write accepted) − rd_ok.
- Same lane, same cycle, write + pop:
  - Both take effect; cnt unchanged.
  - Full is judged on pre-edge cnt, so a write to a full lane is dropped even when a pop occurs in the same cycle.
- Write to an empty lane becomes visible to o_valid in the next cycle; there is no fall-through.
- o_full, o_ready, o_valid are combinational from registered counts only. No combinational path from wr or rd.
- Lanes may fill unevenly (skewed array outputs). o_valid waits for the slowest lane, and leading lanes keep buffering.
- Reset asserted mid-operation discards all contents immediately; out and out_strobe go to 0 asynchronously.

Test Plan:
- Reset then idle → o_valid = 0, o_full = 0, o_ready = 1, out = 0, out_strobe = 0, o_overflow = 0.
- Aligned write: wr = 8'hFF with lane c = c+1 for one cycle, then rd = 1 one cycle later.
  - o_valid = 1 the cycle after the write.
  - out lanes read 1..8 with out_strobe = 1 for one cycle.
  - o_valid = 0 afterwards.
- Skewed writes: lane c written at cycle c (diagonal), values 100+c.
  - o_valid rises only after lane 7's write.
  - A rd issued earlier is ignored with no strobe.
  - A later rd returns 100..107.
- Fill lane 3 with 64 writes → o_full = 1, o_ready = 0.
  - A 65th write to lane 3 sets o_overflow[3] = 1.
  - The lane 3 content stays the first 64 values.
- Wrap-around: 200 rows of streaming writes and reads, with rd held high while o_valid.
  - Output rows match input order, counter values 0..199 in every lane.
  - No strobe gaps while o_valid stays 1.
- Simultaneous write + pop on full lanes: the write is dropped and the overflow flag is set.
  - Separately, async reset mid-stream zeroes out immediately and the next rows restart from empty.

Source files
------------

// File: rtl/psum_ofifo_if.sv
// Bundled handshake and data signals between the MAC array, the read controller
// and the per-column psum output FIFO.
interface psum_ofifo_if #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16
);
  logic [col-1:0]         wr;
  logic [col*psum_bw-1:0] in;
  logic                   rd;
  logic                   o_full;
  logic                   o_ready;
  logic                   o_valid;
  logic [col*psum_bw-1:0] out;
  logic                   out_strobe;
  logic [col-1:0]         o_overflow;

  // Array columns and the read controller drive requests.
  modport master (
    output wr, in, rd,
    input  o_full, o_ready, o_valid, out, out_strobe, o_overflow
  );

  // The FIFO accepts requests and returns status and popped rows.
  modport slave (
    input  wr, in, rd,
    output o_full, o_ready, o_valid, out, out_strobe, o_overflow
  );
endinterface

// File: rtl/psum_ofifo.sv
// Column-lane output FIFO: each lane buffers its column's psums independently;
// a read pops one aligned row from all lanes and presents it registered,
// together with a one-cycle strobe for the downstream sfp stage.
module psum_ofifo #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned depth   = 64
) (
  input logic         clk,
  input logic         reset,
  psum_ofifo_if.slave bus
);
  localparam int unsigned ptr_bw = $clog2(depth);
  localparam int unsigned cnt_bw = ptr_bw + 1;

  logic [ptr_bw-1:0]      wptr_q [col];
  logic [ptr_bw-1:0]      wptr_d [col];
  logic [ptr_bw-1:0]      rptr_q [col];
  logic [ptr_bw-1:0]      rptr_d [col];
  logic [cnt_bw-1:0]      cnt_q  [col];
  logic [cnt_bw-1:0]      cnt_d  [col];
  logic [psum_bw-1:0]     mem_q  [col][depth];
  logic [col-1:0]         full;
  logic [col-1:0]         nonempty;
  logic [col-1:0]         wr_ok;
  logic [col-1:0]         ovf_q, ovf_d;
  logic [col*psum_bw-1:0] out_q, out_d;
  logic                   strobe_q, strobe_d;
  logic                   valid;
  logic                   rd_ok;

  // Per-lane status from registered counts only; no path from wr or rd.
  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int c = 0; c < col; c++) begin
      full[c]     = (cnt_q[c] == cnt_bw'(depth));
      nonempty[c] = (cnt_q[c] != '0);
    end
  end

  assign valid          = &nonempty;
  assign rd_ok          = bus.rd & valid;
  assign wr_ok          = bus.wr & ~full;
  assign bus.o_full     = |full;
  assign bus.o_ready    = ~(|full);
  assign bus.o_valid    = valid;
  assign bus.out        = out_q;
  assign bus.out_strobe = strobe_q;
  assign bus.o_overflow = ovf_q;

  // Next-state: pointers, counts, sticky overflow, and the popped row.
  always_comb begin
    ovf_d    = ovf_q | (bus.wr & full);
    out_d    = out_q;
    strobe_d = rd_ok;
    for (int c = 0; c < col; c++) begin
      wptr_d[c] = wr_ok[c] ? wptr_q[c] + ptr_bw'(1) : wptr_q[c];
      rptr_d[c] = rd_ok ? rptr_q[c] + ptr_bw'(1) : rptr_q[c];
      cnt_d[c]  = cnt_q[c] + cnt_bw'(wr_ok[c]) - cnt_bw'(rd_ok);
      if (rd_ok) begin
        out_d[c*psum_bw +: psum_bw] = mem_q[c][rptr_q[c]];
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      ovf_q    <= '0;
      out_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      ovf_q    <= ovf_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
    end
  end

  // Lane storage; deliberately not reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (wr_ok[c]) begin
        mem_q[c][wptr_q[c]] <= bus.in[c*psum_bw +: psum_bw];
      end
    end
  end
endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: a queue-per-lane reference model predicts status,
// popped rows, strobe and overflow; all outputs are compared every cycle.
module tb_psum_ofifo;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psum_ofifo_if #(.col(COL), .psum_bw(BW)) bus ();

  psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [BW-1:0]     mq [COL][$];
  logic [COL-1:0]    m_ovf;
  logic [COL*BW-1:0] m_out;
  logic              m_strobe;
  int                n_checks = 0;
  int                n_fail   = 0;

  task automatic check_eq(input string tag, input logic [COL*BW-1:0] act,
                          input logic [COL*BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit m_valid();
    for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_full();
    for (int c = 0; c < COL; c++) if (mq[c].size() == DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".o_valid"},    bus.o_valid,    m_valid());
    check_eq({tag, ".o_full"},     bus.o_full,     m_full());
    check_eq({tag, ".o_ready"},    bus.o_ready,    !m_full());
    check_eq({tag, ".out"},        bus.out,        m_out);
    check_eq({tag, ".out_strobe"}, bus.out_strobe, m_strobe);
    check_eq({tag, ".o_overflow"}, bus.o_overflow, m_ovf);
  endtask

  task automatic model_clear();
    for (int c = 0; c < COL; c++) mq[c].delete();
    m_ovf    = '0;
    m_out    = '0;
    m_strobe = 1'b0;
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic step(input string tag);
    bit           rd_ok;
    bit [COL-1:0] acc;
    @(posedge clk);
    rd_ok = bus.rd && m_valid();
    for (int c = 0; c < COL; c++) begin
      acc[c] = bus.wr[c] && (mq[c].size() < DEPTH);
      if (bus.wr[c] && !acc[c]) m_ovf[c] = 1'b1;
    end
    if (rd_ok) for (int c = 0; c < COL; c++) m_out[c*BW +: BW] = mq[c].pop_front();
    m_strobe = rd_ok;
    for (int c = 0; c < COL; c++) if (acc[c]) mq[c].push_back(bus.in[c*BW +: BW]);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [COL-1:0] wr, input logic [COL*BW-1:0] data,
                       input logic rd);
    bus.wr = wr;
    bus.in = data;
    bus.rd = rd;
  endtask

  task automatic do_reset(input string tag);
    drive('0, '0, 1'b0);
    reset = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [COL*BW-1:0] row_of(input int base, input int stride);
    logic [COL*BW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(base + stride * c);
    return r;
  endfunction

  initial begin
    logic [COL*BW-1:0] d;
    reset = 1'b1;
    drive('0, '0, 1'b0);
    #3;
    do_reset("reset");
    step("idle");

    // Aligned single row 1..8.
    drive(8'hFF, row_of(1, 1), 1'b0);
    step("aligned_wr");
    drive('0, '0, 1'b1);
    step("aligned_rd");
    check_eq("aligned_row", bus.out, row_of(1, 1));
    drive('0, '0, 1'b0);
    step("aligned_after");

    // Diagonal writes; early reads must be ignored.
    for (int c = 0; c < COL; c++) begin
      d = '0;
      d[c*BW +: BW] = BW'(100 + c);
      drive(COL'(1) << c, d, c < COL - 1);
      step("skew_wr");
    end
    drive('0, '0, 1'b1);
    step("skew_rd");
    check_eq("skew_row", bus.out, row_of(100, 1));
    drive('0, '0, 1'b0);
    step("skew_after");

    // Overfill lane 3, then fill the rest and drain.
    for (int i = 0; i <= DEPTH; i++) begin
      drive(8'h08, row_of(i, 0), 1'b0);
      step("fill3");
    end
    check_eq("fill3_full", bus.o_full, 1'b1);
    check_eq("fill3_ovf3", bus.o_overflow[3], 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(~8'h08, row_of(1000 + i, 0), 1'b0);
      step("fill_rest");
    end
    drive(8'hFF, row_of(5000, 1), 1'b1);
    step("full_wr_pop");
    check_eq("full_wr_pop_ovf", bus.o_overflow, 8'hFF);
    for (int i = 0; i < DEPTH; i++) begin
      drive('0, '0, 1'b1);
      step("drain");
    end
    drive('0, '0, 1'b0);
    step("drain_end");
    do_reset("reset2");

    // Streaming 200 rows with rd held high.
    for (int k = 0; k < 200; k++) begin
      drive(8'hFF, row_of(k, 0), 1'b1);
      step("stream");
    end
    drive('0, '0, 1'b1);
    repeat (3) step("stream_drain");

    // Random skewed traffic.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < COL; c++) d[c*BW +: BW] = BW'($urandom);
      drive(COL'($urandom), d, 1'($urandom_range(0, 1)));
      step("random");
    end

    // Async reset mid-stream, then restart from empty.
    for (int k = 0; k < 5; k++) begin
      drive(8'hFF, row_of(300 + k, 0), 1'b1);
      step("pre_reset");
    end
    do_reset("mid_reset");
    for (int k = 0; k < 4; k++) begin
      drive(8'hFF, row_of(400 + k, 0), 1'b1);
      step("post_reset");
    end
    drive('0, '0, 1'b1);
    repeat (3) step("post_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
